// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, the canonical NOP and fetch FSM states.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0]   RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } if_state_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {inst,pc} holding slot used when decode stalls with a fetch response in flight.
module if_skid_buffer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [XLEN-1:0]   wr_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic [XLEN-1:0]   rd_pc,
  output logic              full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // Payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rd_inst <= wr_inst;
      rd_pc   <= wr_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding word fetches and feeds the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [riscv_pkg::XLEN-1:0]  imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [riscv_pkg::INST_W-1:0] imem_rdata,
  input  logic                        redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0]  redirect_pc,
  input  logic                        stall,
  output logic [riscv_pkg::INST_W-1:0] inst,
  output logic [riscv_pkg::XLEN-1:0]  pc,
  output logic                        inst_valid
);
  import riscv_pkg::*;

  if_state_t         state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_pc;
  logic              discard;

  logic              resp;
  logic              out_hold;
  logic              skid_wr;
  logic              skid_rd;
  logic              skid_full;
  logic              skid_full_nxt;
  logic [INST_W-1:0] skid_inst;
  logic [XLEN-1:0]   skid_pc;

  assign imem_addr = fetch_pc;

  always_comb begin
    resp     = imem_rvalid && (state == WAIT) && !discard;
    out_hold = inst_valid && stall;
    skid_wr  = !redirect_valid && resp && out_hold;
    skid_rd  = !redirect_valid && !out_hold && skid_full;
    if (redirect_valid || skid_rd) begin
      skid_full_nxt = 1'b0;
    end else if (skid_wr) begin
      skid_full_nxt = 1'b1;
    end else begin
      skid_full_nxt = skid_full;
    end
  end

  if_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (redirect_valid),
    .wr_en   (skid_wr),
    .rd_en   (skid_rd),
    .wr_inst (imem_rdata),
    .wr_pc   (req_pc),
    .rd_inst (skid_inst),
    .rd_pc   (skid_pc),
    .full    (skid_full)
  );

  // Fetch FSM: a new request is only launched once the skid slot is guaranteed empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (state == REQ && imem_gnt) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (state == REQ && imem_gnt) begin
        req_pc <= fetch_pc;
      end

      case (state)
        IDLE: begin
          if (!skid_full_nxt) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            discard  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (!skid_full_nxt) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: redirect flushes, stall holds, skid drains before new responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst       <= NOP_INST;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (out_hold) begin
      inst_valid <= 1'b1;
    end else if (skid_full) begin
      inst       <= skid_inst;
      pc         <= skid_pc;
      inst_valid <= 1'b1;
    end else if (resp) begin
      inst       <= imem_rdata;
      pc         <= req_pc;
      inst_valid <= 1'b1;
    end else begin
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a stream-level reference model of what decode must see.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int tests = 0;
  int fails = 0;
  int rst_epoch = 0;

  bit          gnt_ok = 1'b1;
  int          rv_delay = 1;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  bit          inject = 1'b0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst           (inst),
    .pc             (pc),
    .inst_valid     (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of the memory model; inputs change 1ns after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
    chk("single_outstanding", 32'(imem_req && pending), 32'h0);
    imem_rvalid = 1'b0;
    if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      inject      = 1'b0;
    end else if (pending) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt = imem_req && gnt_ok;
    if (imem_gnt) begin
      pending   = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = rv_delay;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
  endtask

  // Reference model: decode must see consecutive word PCs from the last redirect target,
  // each carrying the memory word at that PC, frozen while stalled, flushed on redirect.
  initial begin
    logic        pv;
    logic [31:0] pi;
    logic [31:0] pp;
    logic [31:0] exp_pc;
    int          epoch_seen;
    pv = 1'b0;
    pi = NOP;
    pp = 32'h0;
    exp_pc = 32'h0;
    epoch_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset || rst_epoch != epoch_seen) begin
        epoch_seen = rst_epoch;
        pv = 1'b0;
        exp_pc = 32'h0;
      end else begin
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'h3;
          chk("m_redirect_flush", 32'(inst_valid), 32'h0);
        end else if (pv && stall) begin
          chk("m_hold_valid", 32'(inst_valid), 32'h1);
          chk("m_hold_inst", inst, pi);
          chk("m_hold_pc", pc, pp);
        end else if (pv) begin
          exp_pc = exp_pc + 32'd4;
        end
        if (inst_valid) begin
          chk("m_pc_order", pc, exp_pc);
          chk("m_inst_data", inst, mem_word(pc));
        end else begin
          chk("m_nop_when_invalid", inst, NOP);
        end
        pv = inst_valid;
        pi = inst;
        pp = pc;
      end
    end
  end

  initial begin
    reset = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    repeat (3) cyc();
    chk_reset_vals();
    reset = 1'b1;

    // Free-running fetch: addresses 0,4,8 and two-cycle gnt-to-valid latency.
    cyc();
    chk("c1_req", 32'(imem_req), 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    cyc();
    chk("c2_not_early", 32'(inst_valid), 32'h0);
    cyc();
    chk("c3_valid", 32'(inst_valid), 32'h1);
    chk("c3_pc", pc, 32'h0);
    chk("c3_inst", inst, 32'hC0DE_0000);
    chk("c3_addr", imem_addr, 32'h4);
    stall = 1'b1;

    // Five stalled cycles: first instruction held, second parked in the skid.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold_pc", pc, 32'h0);
      if (i >= 1) chk("stall_no_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    cyc();
    chk("drain_valid", 32'(inst_valid), 32'h1);
    chk("drain_pc", pc, 32'h4);
    chk("drain_inst", inst, 32'hC0DE_0004);
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, 32'h8);
    cyc();
    rv_delay = 2;
    cyc();
    chk("c11_pc", pc, 32'h8);
    chk("c11_addr", imem_addr, 32'hC);

    // Redirect while the response for 0xC is still outstanding.
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    cyc();
    redirect_valid = 1'b0;
    chk("rd_wait_flush", 32'(inst_valid), 32'h0);
    rv_delay = 1;
    cyc();
    chk("rd_wait_dropped", 32'(inst_valid), 32'h0);
    chk("rd_wait_req", 32'(imem_req), 32'h1);
    chk("rd_wait_addr", imem_addr, 32'h100);
    cyc();
    gnt_ok = 1'b0;
    cyc();
    chk("rd_wait_pc", pc, 32'h100);
    chk("rd_wait_inst", inst, 32'hC0DE_0100);

    // Redirect while the request to 0x104 is not granted.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    redirect_valid = 1'b0;
    chk("rd_req_addr", imem_addr, 32'h200);
    chk("rd_req_req", 32'(imem_req), 32'h1);
    gnt_ok = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rd_req_valid", 32'(inst_valid), 32'h1);
    chk("rd_req_pc", pc, 32'h200);

    // Redirect with output full, skid full and stall asserted.
    stall = 1'b1;
    cyc();
    cyc();
    chk("skid_full_no_req", 32'(imem_req), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    cyc();
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("rd_skid_valid", 32'(inst_valid), 32'h0);
    chk("rd_skid_inst", inst, NOP);
    chk("rd_skid_addr", imem_addr, 32'h300);
    cyc();
    gnt_ok = 1'b0;
    cyc();
    chk("rd_skid_pc", pc, 32'h300);

    // Wrap of the PC adder at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    gnt_ok = 1'b1;
    cyc();
    cyc();
    rv_delay = 3;
    cyc();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, 32'h3F21_FFFC);
    stall = 1'b1;

    // Asynchronous reset pulse while a response is pending, then a stale rvalid.
    cyc();
    chk("pre_rst_valid", 32'(inst_valid), 32'h1);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    pending = 1'b0;
    rv_delay = 1;
    inject = 1'b1;
    stall = 1'b0;
    rst_epoch++;
    #1;
    reset = 1'b1;
    cyc();
    chk("post_rst_addr", imem_addr, 32'h0);
    cyc();
    chk("stale_ignored", 32'(inst_valid), 32'h0);
    cyc();
    chk("post_rst_valid", 32'(inst_valid), 32'h1);
    chk("post_rst_inst", inst, 32'hC0DE_0000);
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
